// File: rtl/kdf_pkg.sv
// rtl/kdf_pkg.sv - shared types and constants for the Hirose/PRESENT KDF verifier
package kdf_pkg;

   localparam int KDF_KEY_WIDTH = 128;

   // Default Hirose chaining constant c
   localparam logic [63:0] KDF_HASH_C = 64'h1234567812345678;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_KICK,
      ST_HASH,
      ST_COMPARE,
      ST_DONE
   } kdf_verify_state_t;

   // The packed {password, salt, count} block must fill one hash input exactly
   function automatic bit kdf_widths_ok(input int psw_w, input int salt_w, input int count_w);
      return (psw_w + salt_w + count_w) == KDF_KEY_WIDTH;
   endfunction

endpackage

// File: rtl/hirose_present_wrapper.sv
// rtl/hirose_present_wrapper.sv - Hirose double-block hash over PRESENT-128, one round per cycle
// Key = hash_input, G = hash_input[127:64]:
//   out = {E_K(G) ^ G, E_K(G ^ c) ^ G ^ c}
// Both encryptions share one key schedule and run side by side. end_signal
// rises 31 cycles after rst is released and stays high until the next rst.
module hirose_present_wrapper
   import kdf_pkg::*;
#(
   parameter logic [63:0] HASH_C = KDF_HASH_C
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] hash_input,
   output logic [127:0] hash_output,
   output logic         end_signal
);

   logic [63:0]  r_g;
   logic [63:0]  r_st0;
   logic [63:0]  r_st1;
   logic [127:0] r_key;
   logic [4:0]   r_rc;
   logic         r_end;

   logic [63:0]  w_x0, w_x1, w_s0, w_s1, w_p0, w_p1;
   logic [127:0] w_key_rot;
   logic [127:0] w_key_nxt;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;
         4'h1: return 4'h5;
         4'h2: return 4'h6;
         4'h3: return 4'hB;
         4'h4: return 4'h9;
         4'h5: return 4'h0;
         4'h6: return 4'hA;
         4'h7: return 4'hD;
         4'h8: return 4'h3;
         4'h9: return 4'hE;
         4'hA: return 4'hF;
         4'hB: return 4'h8;
         4'hC: return 4'h4;
         4'hD: return 4'h7;
         4'hE: return 4'h1;
         default: return 4'h2;
      endcase
   endfunction

   assign w_x0 = r_st0 ^ r_key[127:64];
   assign w_x1 = r_st1 ^ r_key[127:64];

   for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      assign w_s0[4*gi +: 4] = sbox(w_x0[4*gi +: 4]);
      assign w_s1[4*gi +: 4] = sbox(w_x1[4*gi +: 4]);
   end

   // Bit permutation: bit i moves to 16*i mod 63, bit 63 stays put
   for (genvar gi = 0; gi < 64; gi++) begin : g_perm
      assign w_p0[(gi == 63) ? 63 : (gi * 16) % 63] = w_s0[gi];
      assign w_p1[(gi == 63) ? 63 : (gi * 16) % 63] = w_s1[gi];
   end

   // 128-bit key schedule: rotate left 61, S-box the top two nibbles, fold in round counter
   assign w_key_rot = {r_key[66:0], r_key[127:67]};
   assign w_key_nxt = {sbox(w_key_rot[127:124]), sbox(w_key_rot[123:120]),
                       w_key_rot[119:67], w_key_rot[66:62] ^ r_rc, w_key_rot[61:0]};

   // Load on rst, then apply rounds 1..31 and freeze with the final round key in r_key
   always_ff @(posedge clk) begin
      if (rst) begin
         r_g   <= hash_input[127:64];
         r_st0 <= hash_input[127:64];
         r_st1 <= hash_input[127:64] ^ HASH_C;
         r_key <= hash_input;
         r_rc  <= 5'd1;
         r_end <= 1'b0;
      end else if (!r_end) begin
         r_st0 <= w_p0;
         r_st1 <= w_p1;
         r_key <= w_key_nxt;
         r_rc  <= r_rc + 5'd1;
         if (r_rc == 5'd31) begin
            r_end <= 1'b1;
         end
      end
   end

   assign hash_output = {r_st0 ^ r_key[127:64] ^ r_g,
                         r_st1 ^ r_key[127:64] ^ r_g ^ HASH_C};
   assign end_signal  = r_end;

endmodule

// File: rtl/kdf_lockout_ctr.sv
// rtl/kdf_lockout_ctr.sv - consecutive-failure counter with saturating lockout flag (KDF_VERIFY_LOCKOUT_EN)
`ifdef KDF_VERIFY_LOCKOUT_EN
module kdf_lockout_ctr #(
   parameter int MAX_FAILS = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_done,
   input  logic i_match,
   output logic o_locked
);

   localparam int CW = $clog2(MAX_FAILS + 1);

   logic [CW-1:0] r_fails;

   // Count failed verifications, clear on a match, saturate at the lockout threshold
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fails <= '0;
      end else if (i_done) begin
         if (i_match) begin
            r_fails <= '0;
         end else if (r_fails != CW'(MAX_FAILS)) begin
            r_fails <= r_fails + 1'b1;
         end
      end
   end

   assign o_locked = (r_fails == CW'(MAX_FAILS));

endmodule
`endif

// File: rtl/kdf_hirose_present_verify.sv
// rtl/kdf_hirose_present_verify.sv - iterated Hirose/PRESENT key re-derivation and reference compare; lockout under KDF_VERIFY_LOCKOUT_EN
module kdf_hirose_present_verify
   import kdf_pkg::*;
#(
   parameter int          SALT_WIDTH  = 64,
   parameter int          COUNT_WIDTH = 32,
   parameter int          PSW_WIDTH   = 32,
   parameter logic [63:0] HASH_C      = KDF_HASH_C,
   parameter int          MAX_FAILS   = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [PSW_WIDTH-1:0]     user_password,
   input  logic [SALT_WIDTH-1:0]    salt,
   input  logic [COUNT_WIDTH-1:0]   count,
   input  logic [KDF_KEY_WIDTH-1:0] ref_key,
   output logic                     busy,
   output logic                     done,
   output logic                     match,
   output logic                     err,
   output logic [COUNT_WIDTH-1:0]   iter_count,
   output logic                     locked
);

   if (!kdf_widths_ok(PSW_WIDTH, SALT_WIDTH, COUNT_WIDTH)) begin : g_width_check
      $error("PSW_WIDTH + SALT_WIDTH + COUNT_WIDTH must equal KDF_KEY_WIDTH");
   end

   if (MAX_FAILS < 1) begin : g_max_fails_check
      $error("MAX_FAILS must be at least 1");
   end

   kdf_verify_state_t r_state, w_next;

   logic [PSW_WIDTH-1:0]     r_pw;
   logic [SALT_WIDTH-1:0]    r_salt;
   logic [COUNT_WIDTH-1:0]   r_count;
   logic [KDF_KEY_WIDTH-1:0] r_ref;
   logic [KDF_KEY_WIDTH-1:0] r_key;
   logic [COUNT_WIDTH-1:0]   r_iter;
   logic                     r_match;
   logic                     r_err;

   logic                     w_locked;
   logic                     w_accept;
   logic                     w_kick;
   logic                     w_last_iter;
   logic                     w_hash_rst;
   logic                     w_end;
   logic [KDF_KEY_WIDTH-1:0] w_hash_in;
   logic [KDF_KEY_WIDTH-1:0] w_hash_out;

   assign w_accept    = start && !w_locked;
   assign w_last_iter = ((r_iter + 1'b1) == r_count);

   // First iteration hashes the packed request; later ones chain the working key
   assign w_hash_in  = (r_iter == '0) ? {r_pw, r_salt, r_count} : r_key;
   assign w_hash_rst = rst || w_kick;

   hirose_present_wrapper #(
      .HASH_C(HASH_C)
   ) u_hash (
      .clk         (clk),
      .rst         (w_hash_rst),
      .hash_input  (w_hash_in),
      .hash_output (w_hash_out),
      .end_signal  (w_end)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and handshake outputs; count==0 still passes COMPARE so the path is CAPTURE, COMPARE, DONE
   always_comb begin
      w_next = r_state;
      busy   = (r_state != ST_IDLE);
      done   = 1'b0;
      w_kick = 1'b0;
      case (r_state)
         ST_IDLE:    if (w_accept) w_next = ST_CAPTURE;
         ST_CAPTURE: w_next = (r_count == '0) ? ST_COMPARE : ST_KICK;
         ST_KICK: begin
            w_kick = 1'b1;
            w_next = ST_HASH;
         end
         ST_HASH:    if (w_end) w_next = w_last_iter ? ST_COMPARE : ST_KICK;
         ST_COMPARE: w_next = ST_DONE;
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default:    w_next = ST_IDLE;
      endcase
   end

   // Request capture, iteration chaining and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pw    <= '0;
         r_salt  <= '0;
         r_count <= '0;
         r_ref   <= '0;
         r_key   <= '0;
         r_iter  <= '0;
         r_match <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_pw    <= user_password;
                  r_salt  <= salt;
                  r_count <= count;
                  r_ref   <= ref_key;
                  r_iter  <= '0;
                  r_match <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               if (r_count == '0) begin
                  r_err   <= 1'b1;
                  r_match <= 1'b0;
               end
            end
            ST_HASH: begin
               if (w_end) begin
                  r_key  <= w_hash_out;
                  r_iter <= r_iter + 1'b1;
               end
            end
            ST_COMPARE: r_match <= !r_err && (r_key == r_ref);
            ST_DONE:    r_key <= '0;
            default: ;
         endcase
      end
   end

`ifdef KDF_VERIFY_LOCKOUT_EN
   kdf_lockout_ctr #(
      .MAX_FAILS(MAX_FAILS)
   ) u_lockout (
      .clk      (clk),
      .rst      (rst),
      .i_done   (done),
      .i_match  (r_match),
      .o_locked (w_locked)
   );
`else
   assign w_locked = 1'b0;
`endif

   assign match      = r_match;
   assign err        = r_err;
   assign iter_count = r_iter;
   assign locked     = w_locked;

endmodule

// File: tb/tb_kdf_hirose_present_verify.sv
// tb/tb_kdf_hirose_present_verify.sv - directed self-checking bench for kdf_hirose_present_verify
module tb_kdf_hirose_present_verify;

   localparam logic [63:0] SALT   = 64'h0123456789ABCDEF;
   localparam logic [63:0] C      = 64'h1234567812345678;
   localparam int          L      = 32;
   localparam int          BOUND  = 300;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [31:0]  user_password;
   logic [63:0]  salt;
   logic [31:0]  count;
   logic [127:0] ref_key;
   logic         busy, done, match, err, locked;
   logic [31:0]  iter_count;

   int n_checks = 0;
   int n_fail   = 0;
   int n_kick   = 0;
   int n_done   = 0;

   kdf_hirose_present_verify dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .user_password (user_password),
      .salt          (salt),
      .count         (count),
      .ref_key       (ref_key),
      .busy          (busy),
      .done          (done),
      .match         (match),
      .err           (err),
      .iter_count    (iter_count),
      .locked        (locked)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dut.w_kick) n_kick++;
      if (done) n_done++;
   end

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [3:0] ref_sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   function automatic logic [63:0] ref_enc(input logic [127:0] key, input logic [63:0] pt);
      logic [127:0] k;
      logic [63:0]  s, u, p;
      k = key;
      s = pt;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[127:64];
         u = '0;
         for (int i = 0; i < 16; i++) u = u | (64'(ref_sbox(4'(s >> (4 * i)))) << (4 * i));
         p = '0;
         for (int i = 0; i < 64; i++) p = p | (((u >> i) & 64'd1) << (16 * (i % 4) + i / 4));
         s = p;
         k = {k[66:0], k[127:67]};
         k[127:124] = ref_sbox(k[127:124]);
         k[123:120] = ref_sbox(k[123:120]);
         k[66:62]   = k[66:62] ^ 5'(r);
      end
      return s ^ k[127:64];
   endfunction

   function automatic logic [127:0] ref_hash(input logic [127:0] x);
      logic [63:0] g;
      g = x[127:64];
      return {ref_enc(x, g) ^ g, ref_enc(x, g ^ C) ^ g ^ C};
   endfunction

   function automatic logic [127:0] ref_kdf(input logic [31:0] pw, input logic [63:0] sl, input int n);
      logic [127:0] k;
      k = {pw, sl, 32'(n)};
      for (int i = 0; i < n; i++) k = ref_hash(k);
      return k;
   endfunction

   task automatic run_req(input logic [31:0] pw, input logic [127:0] rk, input logic [31:0] cnt,
                          input int spur_a, input int spur_b, input int bound,
                          output int lat, output int kicks, output int dones, output logic saw_busy);
      int cyc, k0, d0;
      @(negedge clk);
      k0 = n_kick;
      d0 = n_done;
      user_password = pw;
      salt          = SALT;
      ref_key       = rk;
      count         = cnt;
      start         = 1'b1;
      lat           = -1;
      cyc           = 0;
      saw_busy      = 1'b0;
      while (lat < 0 && cyc < bound) begin
         @(posedge clk);
         #1;
         cyc++;
         start = (cyc == spur_a) || (cyc == spur_b);
         if (start) begin
            user_password = 32'h2;
            ref_key       = ~rk;
         end
         saw_busy = saw_busy | busy;
         if (done) lat = cyc;
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      kicks = n_kick - k0;
      dones = n_done - d0;
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [127:0] g1, g2, g3, gp1;
   int           lat, kicks, dones, cyc, d0;
   logic         sb;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      user_password = '0;
      salt = '0;
      count = '0;
      ref_key = '0;
      g1  = ref_kdf(32'hCAFEBABE, SALT, 1);
      g2  = ref_kdf(32'hCAFEBABE, SALT, 2);
      g3  = ref_kdf(32'hCAFEBABE, SALT, 3);
      gp1 = ref_kdf(32'h1, SALT, 2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      check_val("rst_busy",   128'(busy),       128'(0));
      check_val("rst_done",   128'(done),       128'(0));
      check_val("rst_match",  128'(match),      128'(0));
      check_val("rst_err",    128'(err),        128'(0));
      check_val("rst_iter",   128'(iter_count), 128'(0));
      check_val("rst_locked", 128'(locked),     128'(0));

      // count=1, correct reference
      run_req(32'hCAFEBABE, g1, 32'd1, -1, -1, BOUND, lat, kicks, dones, sb);
      check_val("c1_latency", 128'(lat),        128'(3 + 1 * (1 + L)));
      check_val("c1_kicks",   128'(kicks),      128'(1));
      check_val("c1_dones",   128'(dones),      128'(1));
      check_val("c1_match",   128'(match),      128'(1));
      check_val("c1_err",     128'(err),        128'(0));
      check_val("c1_iter",    128'(iter_count), 128'(1));

      // count=3, reference with bit 0 flipped
      run_req(32'hCAFEBABE, g3 ^ 128'd1, 32'd3, -1, -1, BOUND, lat, kicks, dones, sb);
      check_val("c3_latency", 128'(lat),        128'(3 + 3 * (1 + L)));
      check_val("c3_kicks",   128'(kicks),      128'(3));
      check_val("c3_dones",   128'(dones),      128'(1));
      check_val("c3_match",   128'(match),      128'(0));
      check_val("c3_err",     128'(err),        128'(0));
      check_val("c3_iter",    128'(iter_count), 128'(3));

      // count=0 request
      run_req(32'hCAFEBABE, g1, 32'd0, -1, -1, BOUND, lat, kicks, dones, sb);
      check_val("c0_latency", 128'(lat),        128'(3));
      check_val("c0_kicks",   128'(kicks),      128'(0));
      check_val("c0_err",     128'(err),        128'(1));
      check_val("c0_match",   128'(match),      128'(0));
      check_val("c0_iter",    128'(iter_count), 128'(0));

      // Starts while busy (one cycle later, mid-HASH) carry pw=2 and a wrong ref; must be ignored
      run_req(32'h1, gp1, 32'd2, 1, 20, BOUND, lat, kicks, dones, sb);
      check_val("ign_latency", 128'(lat),        128'(3 + 2 * (1 + L)));
      check_val("ign_kicks",   128'(kicks),      128'(2));
      check_val("ign_dones",   128'(dones),      128'(1));
      check_val("ign_match",   128'(match),      128'(1));
      check_val("ign_iter",    128'(iter_count), 128'(2));

      // Reset during iteration 2 of a count=4 run
      @(negedge clk);
      user_password = 32'hCAFEBABE;
      salt          = SALT;
      count         = 32'd4;
      ref_key       = g1;
      start         = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      while (iter_count != 32'd1 && cyc < BOUND) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_val("rst_mid_reach", 128'(iter_count), 128'(1));
      d0 = n_done;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_mid_busy",   128'(busy),       128'(0));
      check_val("rst_mid_done",   128'(done),       128'(0));
      check_val("rst_mid_match",  128'(match),      128'(0));
      check_val("rst_mid_err",    128'(err),        128'(0));
      check_val("rst_mid_iter",   128'(iter_count), 128'(0));
      check_val("rst_mid_locked", 128'(locked),     128'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check_val("rst_mid_nodone", 128'(n_done - d0), 128'(0));

      run_req(32'hCAFEBABE, g2, 32'd2, -1, -1, BOUND, lat, kicks, dones, sb);
      check_val("fresh_latency", 128'(lat),        128'(3 + 2 * (1 + L)));
      check_val("fresh_match",   128'(match),      128'(1));
      check_val("fresh_iter",    128'(iter_count), 128'(2));

`ifdef KDF_VERIFY_LOCKOUT_EN
      pulse_rst();
      run_req(32'hCAFEBABE, g1, 32'd0, -1, -1, BOUND, lat, kicks, dones, sb);
      run_req(32'hCAFEBABE, g1, 32'd0, -1, -1, BOUND, lat, kicks, dones, sb);
      check_val("lk_two_fails", 128'(locked), 128'(0));
      run_req(32'hCAFEBABE, g1, 32'd1, -1, -1, BOUND, lat, kicks, dones, sb);
      check_val("lk_match_ok",  128'(match),  128'(1));
      run_req(32'hCAFEBABE, g1, 32'd0, -1, -1, BOUND, lat, kicks, dones, sb);
      run_req(32'hCAFEBABE, g1, 32'd0, -1, -1, BOUND, lat, kicks, dones, sb);
      check_val("lk_cleared",   128'(locked), 128'(0));
      run_req(32'hCAFEBABE, g1 ^ 128'd1, 32'd1, -1, -1, BOUND, lat, kicks, dones, sb);
      check_val("lk_locked",    128'(locked), 128'(1));
      run_req(32'hCAFEBABE, g1, 32'd1, -1, -1, 10, lat, kicks, dones, sb);
      check_val("lk_no_busy",   128'(sb),     128'(0));
      check_val("lk_no_done",   128'(dones),  128'(0));
      check_val("lk_still",     128'(locked), 128'(1));
      pulse_rst();
      check_val("lk_rst_clear", 128'(locked), 128'(0));
`else
      for (int i = 0; i < 5; i++) begin
         run_req(32'hCAFEBABE, g1, 32'd0, -1, -1, BOUND, lat, kicks, dones, sb);
      end
      check_val("nolk_five_fails", 128'(locked), 128'(0));
      run_req(32'hCAFEBABE, g1, 32'd1, -1, -1, BOUND, lat, kicks, dones, sb);
      check_val("nolk_still_runs", 128'(match),  128'(1));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
